// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle of the raster timing generator: the two control
// inputs plus every registered timing/pattern output.
interface video_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           i_en;
    logic           i_pattern_en;
    logic           o_hsync;
    logic           o_vsync;
    logic           o_de;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;
    logic           o_frame_start;
    logic [23:0]    o_rgb;

    // Controller side: drives enables, consumes the raster.
    modport master (
        output i_en, i_pattern_en,
        input  o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_rgb
    );

    // Generator side.
    modport slave (
        input  i_en, i_pattern_en,
        output o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_rgb
    );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator, one pixel per clock. The counters
// describe the pixel being generated; every output is registered from the
// same counter state so sync, de, coordinates and colour stay aligned.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    video_timing_gen_if.slave  vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BP_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam bit SYNC_ON = (SYNC_POL != 0);

    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    // Raster position and bar tracker for the pixel currently being generated
    logic [X_W-1:0]  h_cnt, h_nxt;
    logic [Y_W-1:0]  v_cnt, v_nxt;
    logic [BP_W-1:0] bar_px, bar_px_nxt;
    logic [2:0]      bar_idx, bar_idx_nxt;

    // Decoded attributes of the current pixel
    logic        h_last, v_last;
    logic        active, hs_on, vs_on, at_origin;
    logic [23:0] rgb_cur;

    // Output registers
    logic           hsync_q, vsync_q, de_q, fs_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [23:0]    rgb_q;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;  // white
            3'd1:    c = 24'hFFFF00;  // yellow
            3'd2:    c = 24'h00FFFF;  // cyan
            3'd3:    c = 24'h00FF00;  // green
            3'd4:    c = 24'hFF00FF;  // magenta
            3'd5:    c = 24'hFF0000;  // red
            3'd6:    c = 24'h0000FF;  // blue
            default: c = 24'h000000;  // black
        endcase
        return c;
    endfunction

    // Decode the current pixel and compute the next raster position
    always_comb begin
        h_last      = (int'(h_cnt) == H_TOTAL - 1);
        v_last      = (int'(v_cnt) == V_TOTAL - 1);
        active      = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hs_on       = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
        vs_on       = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);
        at_origin   = (h_cnt == '0) && (v_cnt == '0);
        rgb_cur     = (active && vif.i_pattern_en) ? bar_color(bar_idx) : 24'h0;

        h_nxt       = h_cnt + X_W'(1);
        v_nxt       = v_cnt;
        bar_px_nxt  = bar_px + BP_W'(1);
        bar_idx_nxt = bar_idx;

        if (h_last) begin
            h_nxt       = '0;
            v_nxt       = v_last ? '0 : v_cnt + Y_W'(1);
            bar_px_nxt  = '0;
            bar_idx_nxt = '0;
        end else if (int'(bar_px) == BAR_W - 1) begin
            // Bar boundary: step the index instead of dividing h_cnt.
            // Past the active region the index may wrap; rgb is masked there.
            bar_px_nxt  = '0;
            bar_idx_nxt = bar_idx + 3'd1;
        end
    end

    // Raster counters advance only while enabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (vif.i_en) begin
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            bar_px  <= bar_px_nxt;
            bar_idx <= bar_idx_nxt;
        end
    end

    // Register the current pixel's attributes; freeze on disable except the
    // frame-start pulse, which must not repeat while the raster is held
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= 24'h0;
        end else if (vif.i_en) begin
            hsync_q <= hs_on ? SYNC_ON : ~SYNC_ON;
            vsync_q <= vs_on ? SYNC_ON : ~SYNC_ON;
            de_q    <= active;
            fs_q    <= at_origin;
            x_q     <= h_cnt;
            y_q     <= v_cnt;
            rgb_q   <= rgb_cur;
        end else begin
            fs_q    <= 1'b0;
        end
    end

    assign vif.o_hsync       = hsync_q;
    assign vif.o_vsync       = vsync_q;
    assign vif.o_de          = de_q;
    assign vif.o_frame_start = fs_q;
    assign vif.o_x           = x_q;
    assign vif.o_y           = y_q;
    assign vif.o_rgb         = rgb_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a full-size 640x480 instance (line-level
// timing, colour bars, freeze, pattern gating) and a tiny SYNC_POL=1
// instance (frame-level timing, async mid-frame reset). Expected pixels are
// queued per reset epoch and sample index; monitors pop them as samples come.
module tb_video_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    video_timing_gen_if #(.X_W(10), .Y_W(10)) ifa ();
    video_timing_gen_if #(.X_W(5),  .Y_W(3))  ifb ();

    video_timing_gen dut_a (.i_clk(clk), .i_rst(rst_a), .vif(ifa));

    // 24x8 raster: active 16x4, hsync x=18..20, vsync y=5..6, bars 2 px wide
    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1)
    ) dut_b (.i_clk(clk), .i_rst(rst_b), .vif(ifb));

    typedef struct {
        int          epoch;
        int          s;
        int          x;
        int          y;
        bit          de;
        bit          hs;
        bit          vs;
        bit          fs;
        logic [23:0] rgb;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks   = 0;
    int failures = 0;
    int smp      = 0;

    function automatic logic [63:0] pk(input int x, input int y, input bit de, input bit hs,
                                       input bit vs, input bit fs, input logic [23:0] rgb);
        return {4'b0, x[15:0], y[15:0], de, hs, vs, fs, rgb};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (x16,y16,de/hs/vs/fs,rgb24)", name, act, req);
        end
    endtask

    task automatic push_a(input int s, input int x, input int y, input bit de, input bit hs,
                          input bit vs, input bit fs, input logic [23:0] rgb);
        qa.push_back('{1, s, x, y, de, hs, vs, fs, rgb});
    endtask

    task automatic push_b(input int ep, input int s, input int x, input int y, input bit de,
                          input bit hs, input bit vs, input bit fs, input logic [23:0] rgb);
        qb.push_back('{ep, s, x, y, de, hs, vs, fs, rgb});
    endtask

    task automatic wait_to(input int s);
        while (smp < s + 1) begin
            @(negedge clk);
            smp++;
        end
    endtask

    // Monitor A: one sample per negedge after reset release
    int   ep_a = 0, cnt_a = 0, de_cnt = 0, hs_low = 0;
    bit   prev_a = 1'b1;
    exp_t ea;
    always @(negedge clk) begin
        if (rst_a) begin
            prev_a = 1'b1;
        end else begin
            if (prev_a) begin
                ep_a++;
                cnt_a  = 0;
                prev_a = 1'b0;
            end
            if (ep_a == 1 && cnt_a < 800) begin
                de_cnt += int'(ifa.o_de);
                hs_low += int'(!ifa.o_hsync);
            end
            while (qa.size() > 0 && qa[0].epoch == ep_a && qa[0].s == cnt_a) begin
                ea = qa.pop_front();
                check($sformatf("A_e%0d_s%0d", ea.epoch, ea.s),
                      pk(int'(ifa.o_x), int'(ifa.o_y), ifa.o_de, ifa.o_hsync, ifa.o_vsync,
                         ifa.o_frame_start, ifa.o_rgb),
                      pk(ea.x, ea.y, ea.de, ea.hs, ea.vs, ea.fs, ea.rgb));
            end
            cnt_a++;
        end
    end

    // Monitor B: sample index restarts with each reset release (new epoch)
    int   ep_b = 0, cnt_b = 0, vs_hi = 0;
    bit   prev_b = 1'b1;
    exp_t eb;
    always @(negedge clk) begin
        if (rst_b) begin
            prev_b = 1'b1;
        end else begin
            if (prev_b) begin
                ep_b++;
                cnt_b  = 0;
                prev_b = 1'b0;
            end
            if (ep_b == 1 && cnt_b < 192)
                vs_hi += int'(ifb.o_vsync);
            while (qb.size() > 0 && qb[0].epoch == ep_b && qb[0].s == cnt_b) begin
                eb = qb.pop_front();
                check($sformatf("B_e%0d_s%0d", eb.epoch, eb.s),
                      pk(int'(ifb.o_x), int'(ifb.o_y), ifb.o_de, ifb.o_hsync, ifb.o_vsync,
                         ifb.o_frame_start, ifb.o_rgb),
                      pk(eb.x, eb.y, eb.de, eb.hs, eb.vs, eb.fs, eb.rgb));
            end
            cnt_b++;
        end
    end

    initial begin
        ifa.i_en = 1'b1; ifa.i_pattern_en = 1'b1;
        ifb.i_en = 1'b1; ifb.i_pattern_en = 1'b1;

        // A, active-low syncs: idle hs=vs=1. Line 0 bars, porch and hsync edges.
        push_a(0,    0,   0, 1, 1, 1, 1, 24'hFFFFFF);
        push_a(1,    1,   0, 1, 1, 1, 0, 24'hFFFFFF);
        push_a(79,   79,  0, 1, 1, 1, 0, 24'hFFFFFF);
        push_a(80,   80,  0, 1, 1, 1, 0, 24'hFFFF00);
        push_a(559,  559, 0, 1, 1, 1, 0, 24'h0000FF);
        push_a(560,  560, 0, 1, 1, 1, 0, 24'h000000);
        push_a(639,  639, 0, 1, 1, 1, 0, 24'h000000);
        push_a(640,  640, 0, 0, 1, 1, 0, 24'h000000);
        push_a(655,  655, 0, 0, 1, 1, 0, 24'h000000);
        push_a(656,  656, 0, 0, 0, 1, 0, 24'h000000);
        push_a(751,  751, 0, 0, 0, 1, 0, 24'h000000);
        push_a(752,  752, 0, 0, 1, 1, 0, 24'h000000);
        push_a(799,  799, 0, 0, 1, 1, 0, 24'h000000);
        push_a(800,  0,   1, 1, 1, 1, 0, 24'hFFFFFF);
        // Freeze at (100,1) for 37 cycles, then resume at 101
        push_a(900,  100, 1, 1, 1, 1, 0, 24'hFFFF00);
        push_a(901,  100, 1, 1, 1, 1, 0, 24'hFFFF00);
        push_a(937,  100, 1, 1, 1, 1, 0, 24'hFFFF00);
        push_a(938,  101, 1, 1, 1, 1, 0, 24'hFFFF00);
        // Pattern off for one pixel window, then back on
        push_a(951,  114, 1, 1, 1, 1, 0, 24'h000000);
        push_a(961,  124, 1, 1, 1, 1, 0, 24'hFFFF00);
        // Line 1 still exactly 800 pixels, offset by the 37 frozen cycles
        push_a(1636, 799, 1, 0, 1, 1, 0, 24'h000000);
        push_a(1637, 0,   2, 1, 1, 1, 0, 24'hFFFFFF);

        // B, active-high syncs: idle hs=vs=0
        push_b(1, 0,   0,  0, 1, 0, 0, 1, 24'hFFFFFF);
        push_b(1, 3,   3,  0, 1, 0, 0, 0, 24'hFFFF00);
        push_b(1, 4,   4,  0, 1, 0, 0, 0, 24'h00FFFF);
        push_b(1, 13,  13, 0, 1, 0, 0, 0, 24'h0000FF);
        push_b(1, 14,  14, 0, 1, 0, 0, 0, 24'h000000);
        push_b(1, 16,  16, 0, 0, 0, 0, 0, 24'h000000);
        push_b(1, 17,  17, 0, 0, 0, 0, 0, 24'h000000);
        push_b(1, 18,  18, 0, 0, 1, 0, 0, 24'h000000);
        push_b(1, 20,  20, 0, 0, 1, 0, 0, 24'h000000);
        push_b(1, 21,  21, 0, 0, 0, 0, 0, 24'h000000);
        push_b(1, 24,  0,  1, 1, 0, 0, 0, 24'hFFFFFF);
        push_b(1, 96,  0,  4, 0, 0, 0, 0, 24'h000000);
        push_b(1, 119, 23, 4, 0, 0, 0, 0, 24'h000000);
        push_b(1, 120, 0,  5, 0, 0, 1, 0, 24'h000000);
        push_b(1, 167, 23, 6, 0, 0, 1, 0, 24'h000000);
        push_b(1, 168, 0,  7, 0, 0, 0, 0, 24'h000000);
        push_b(1, 191, 23, 7, 0, 0, 0, 0, 24'h000000);
        push_b(1, 192, 0,  0, 1, 0, 0, 1, 24'hFFFFFF);
        push_b(1, 211, 19, 0, 0, 1, 0, 0, 24'h000000);
        // After the mid-frame reset the raster restarts at the origin
        push_b(2, 0,   0,  0, 1, 0, 0, 1, 24'hFFFFFF);
        push_b(2, 2,   2,  0, 1, 0, 0, 0, 24'hFFFF00);
        push_b(2, 24,  0,  1, 1, 0, 0, 0, 24'hFFFFFF);

        repeat (3) @(negedge clk);
        check("A_reset_state",
              pk(int'(ifa.o_x), int'(ifa.o_y), ifa.o_de, ifa.o_hsync, ifa.o_vsync,
                 ifa.o_frame_start, ifa.o_rgb),
              pk(0, 0, 0, 1, 1, 0, 24'h0));
        check("B_reset_state",
              pk(int'(ifb.o_x), int'(ifb.o_y), ifb.o_de, ifb.o_hsync, ifb.o_vsync,
                 ifb.o_frame_start, ifb.o_rgb),
              pk(0, 0, 0, 0, 0, 0, 24'h0));
        #1 rst_a = 1'b0; rst_b = 1'b0;
        smp = 0;

        // Mid-frame reset of B while hsync is asserted; outputs clear before any edge
        wait_to(211);
        #2 rst_b = 1'b1;
        #1 check("B_async_reset",
                 pk(int'(ifb.o_x), int'(ifb.o_y), ifb.o_de, ifb.o_hsync, ifb.o_vsync,
                    ifb.o_frame_start, ifb.o_rgb),
                 pk(0, 0, 0, 0, 0, 0, 24'h0));
        wait_to(214);
        #1 rst_b = 1'b0;

        wait_to(900);
        #1 ifa.i_en = 1'b0;
        wait_to(937);
        #1 ifa.i_en = 1'b1;
        wait_to(950);
        #1 ifa.i_pattern_en = 1'b0;
        wait_to(960);
        #1 ifa.i_pattern_en = 1'b1;

        wait_to(1700);
        check("A_de_per_line",    64'(de_cnt), 64'd640);
        check("A_hsync_per_line", 64'(hs_low), 64'd96);
        check("B_vsync_per_frame", 64'(vs_hi), 64'd48);
        check("A_unconsumed", 64'(qa.size()), 64'd0);
        check("B_unconsumed", 64'(qb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
